mio_bus_ctrl: RTL and testbench

//  Memory/IO bus controller directly downstream of the pipelined CPU's MIO port. Accepts one

---
 rtl/mio_pkg.sv | 31 +++
 rtl/mio_bus_ctrl_if.sv | 22 ++
 rtl/mio_timer.sv | 33 +++
 rtl/mio_bus_ctrl.sv | 138 +++++++++++++
 tb/tb_mio_bus_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus controller: address regions, region nibbles,
// FSM state encoding and the address decoder.
package mio_pkg;

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_GPIO = 2'd1,
      REG_TMR  = 2'd2,
      REG_NONE = 2'd3
   } region_t;

   localparam logic [3:0] NIB_RAM  = 4'h0;
   localparam logic [3:0] NIB_GPIO = 4'hE;
   localparam logic [3:0] NIB_TMR  = 4'hF;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   function automatic region_t decode_region(input logic [3:0] nib);
      region_t r;
      case (nib)
         NIB_RAM:  r = REG_RAM;
         NIB_GPIO: r = REG_GPIO;
         NIB_TMR:  r = REG_TMR;
         default:  r = REG_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side MIO handshake: request/address/data from the CPU, data and ready pulse back.
interface mio_bus_ctrl_if;
   import mio_pkg::*;

   logic        cpu_req;
   logic        mem_w;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic [31:0] rdata_out;
   logic        MIO_ready;

   modport master (
      output cpu_req, mem_w, addr_in, wdata_in,
      input  rdata_out, MIO_ready
   );

   modport slave (
      input  cpu_req, mem_w, addr_in, wdata_in,
      output rdata_out, MIO_ready
   );

endinterface

// File: rtl/mio_timer.sv
// Free-running 32-bit timer with synchronous load and a one-cycle pulse on wrap to zero.
module mio_timer
   import mio_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_en,
   input  logic [31:0] load_val,
   output logic [31:0] cnt_val,
   output logic        cnt_irq
);

   logic [31:0] cnt_r;
   logic        irq_r;

   // Counter update; a load wins over the increment and never raises the interrupt.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= 32'h0000_0000;
         irq_r <= 1'b0;
      end else if (load_en) begin
         cnt_r <= load_val;
         irq_r <= 1'b0;
      end else begin
         cnt_r <= cnt_r + 32'd1;
         irq_r <= (cnt_r == 32'hFFFF_FFFF);
      end
   end

   assign cnt_val = cnt_r;
   assign cnt_irq = irq_r;

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: accepts one CPU load/store per handshake, decodes it to
// RAM (with wait states), GPIO or timer, and returns a one-cycle MIO_ready pulse.
module mio_bus_ctrl
   import mio_pkg::*;
#(
   parameter int RAM_WAIT = 2,
   parameter int RAM_AW   = 10
) (
   input  logic              clk,
   input  logic              reset,
   mio_bus_ctrl_if.slave     cpu,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   input  logic [31:0]       gpio_in,
   output logic [31:0]       gpio_out,
   output logic              cnt_irq
);

   localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT - 1);
   localparam bit         ONE_WAIT  = (RAM_WAIT == 1);

   logic [1:0]        state_r;
   logic [3:0]        wait_cnt_r;
   logic              mem_w_r;
   logic              ready_r;
   logic [31:0]       rdata_r;
   logic              ram_en_r;
   logic              ram_we_r;
   logic [RAM_AW-1:0] ram_addr_r;
   logic [31:0]       ram_din_r;
   logic [31:0]       gpio_r;
   logic [31:0]       tmr_cnt_s;
   region_t           region_s;
   logic              accept_s;
   logic              tmr_load_s;
   logic              unused_s;

   // Address decode and the accept condition seen by the timer's load port.
   always_comb begin
      region_s   = decode_region(cpu.addr_in[31:28]);
      accept_s   = (state_r == ST_IDLE) && cpu.cpu_req;
      tmr_load_s = accept_s && cpu.mem_w && (region_s == REG_TMR);
   end

   assign unused_s = ^{cpu.addr_in};

   mio_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load_en  (tmr_load_s),
      .load_val (cpu.wdata_in),
      .cnt_val  (tmr_cnt_s),
      .cnt_irq  (cnt_irq)
   );

   // Transaction FSM; request fields are sampled only when accepted in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= 4'd0;
         mem_w_r    <= 1'b0;
         ready_r    <= 1'b0;
         rdata_r    <= 32'h0000_0000;
         ram_en_r   <= 1'b0;
         ram_we_r   <= 1'b0;
         ram_addr_r <= '0;
         ram_din_r  <= 32'h0000_0000;
         gpio_r     <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ready_r <= 1'b0;
               if (cpu.cpu_req) begin
                  mem_w_r    <= cpu.mem_w;
                  ram_addr_r <= cpu.addr_in[RAM_AW+1:2];
                  ram_din_r  <= cpu.wdata_in;
                  if (region_s == REG_RAM) begin
                     state_r    <= ST_WAIT;
                     ram_en_r   <= 1'b1;
                     ram_we_r   <= cpu.mem_w && ONE_WAIT;
                     wait_cnt_r <= WAIT_LAST;
                  end else begin
                     state_r <= ST_READY;
                     ready_r <= 1'b1;
                     case (region_s)
                        REG_GPIO: rdata_r <= gpio_in;
                        REG_TMR:  rdata_r <= tmr_cnt_s;
                        default:  rdata_r <= 32'h0000_0000;
                     endcase
                     if (cpu.mem_w && (region_s == REG_GPIO)) begin
                        gpio_r <= cpu.wdata_in;
                     end else begin
                        gpio_r <= gpio_r;
                     end
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (wait_cnt_r == 4'd0) begin
                  state_r  <= ST_READY;
                  ready_r  <= 1'b1;
                  ram_en_r <= 1'b0;
                  ram_we_r <= 1'b0;
                  rdata_r  <= ram_dout;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 4'd1;
                  // Strobe lands on the last WAIT cycle, which is when the count reaches 0.
                  ram_we_r   <= mem_w_r && (wait_cnt_r == 4'd1);
               end
            end
            ST_READY: begin
               ready_r <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               ready_r  <= 1'b0;
               ram_en_r <= 1'b0;
               ram_we_r <= 1'b0;
            end
         endcase
      end
   end

   assign cpu.MIO_ready = ready_r;
   assign cpu.rdata_out = rdata_r;
   assign ram_en        = ram_en_r;
   assign ram_we        = ram_we_r;
   assign ram_addr      = ram_addr_r;
   assign ram_din       = ram_din_r;
   assign gpio_out      = gpio_r;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: a transaction-level model predicts ready timing,
// read data, RAM strobes, GPIO and the timer interrupt; a per-cycle process compares.
module tb_mio_bus_ctrl;

   localparam int RAM_WAIT = 2;
   localparam int RAM_AW   = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mio_bus_ctrl_if bus();
   logic              ram_en, ram_we, cnt_irq;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_din, ram_dout, gpio_in, gpio_out;

   mio_bus_ctrl #(.RAM_WAIT(RAM_WAIT), .RAM_AW(RAM_AW)) dut (
      .clk(clk), .reset(reset), .cpu(bus),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .gpio_in(gpio_in), .gpio_out(gpio_out), .cnt_irq(cnt_irq)
   );

   // Synchronous RAM environment, read-first, 1-cycle latency.
   logic [31:0] mem [0:(1<<RAM_AW)-1];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         ram_dout <= mem[ram_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_err = 0;
   int n_chk = 0;

   // Model state.
   logic [31:0]       m_gpio = 32'h0;
   int                m_ready_cyc = -1;
   int                m_we_cyc = -1;
   logic [RAM_AW-1:0] m_we_addr = '0;
   int                base_cyc = 0;
   logic [31:0]       base_val = 32'h0;
   bit                m_irq_en = 1'b0;
   bit                chk_en = 1'b0;
   logic [31:0]       exp_ram [int];

   int          s_cyc, exp_lat, last_lat;
   logic [31:0] exp_rd, last_rd, cur_addr, cur_wd;
   bit          cur_w, cur_ram;
   logic [3:0]  cur_nib;

   int irq_cnt = 0, irq_cyc = -1, we_cnt = 0;
   logic [RAM_AW-1:0] we_addr_seen = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: cycle %0d got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] m_timer(input int c);
      return base_val + 32'(c - base_cyc);
   endfunction

   // Per-cycle comparison of every always-meaningful output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         #2;
         chk("MIO_ready", 32'(bus.MIO_ready), 32'(cyc == m_ready_cyc));
         chk("ram_we", 32'(ram_we), 32'(cyc == m_we_cyc));
         if (cyc == m_we_cyc) chk("ram_addr", 32'(ram_addr), 32'(m_we_addr));
         chk("gpio_out", gpio_out, m_gpio);
         chk("cnt_irq", 32'(cnt_irq),
             32'(m_irq_en && (cyc > base_cyc) && (m_timer(cyc) == 32'h0)));
      end
   end

   // Event counters used by the hand-computed literal checks.
   always @(negedge clk) begin
      if (cnt_irq === 1'b1) begin irq_cnt++; irq_cyc = cyc; end
      if (ram_we === 1'b1) begin we_cnt++; we_addr_seen = ram_addr; end
   end

   task automatic pulse_reset(input int n, input bit hold_req);
      reset = 1'b1;
      bus.cpu_req = hold_req; bus.mem_w = 1'b1;
      bus.addr_in = 32'h0000_0010; bus.wdata_in = 32'hDEAD_BEEF;
      repeat (n) begin
         @(negedge clk);
         m_irq_en = 1'b0; m_gpio = 32'h0; m_ready_cyc = -1; m_we_cyc = -1; chk_en = 1'b1;
         chk("rst MIO_ready", 32'(bus.MIO_ready), 32'd0);
         chk("rst ram_we", 32'(ram_we), 32'd0);
         chk("rst gpio_out", gpio_out, 32'd0);
         chk("rst cnt_irq", 32'(cnt_irq), 32'd0);
      end
      reset = 1'b0; bus.cpu_req = 1'b0;
      base_cyc = cyc; base_val = 32'h0; m_irq_en = 1'b1;
   endtask

   // Issue a request at a negedge while the controller is idle; returns one cycle later.
   task automatic start_acc(input bit w, input logic [31:0] a, input logic [31:0] d);
      bus.cpu_req = 1'b1; bus.mem_w = w; bus.addr_in = a; bus.wdata_in = d;
      s_cyc = cyc; cur_w = w; cur_addr = a; cur_wd = d; cur_nib = a[31:28];
      cur_ram = (cur_nib == 4'h0);
      exp_lat = cur_ram ? 1 + RAM_WAIT : 1;
      m_ready_cyc = s_cyc + exp_lat;
      if (cur_ram && w) begin m_we_cyc = s_cyc + RAM_WAIT; m_we_addr = a[RAM_AW+1:2]; end
      case (cur_nib)
         4'h0: exp_rd = exp_ram.exists(int'(a[RAM_AW+1:2])) ? exp_ram[int'(a[RAM_AW+1:2])] : 32'h0;
         4'hE: exp_rd = gpio_in;
         4'hF: exp_rd = m_timer(s_cyc);
         default: exp_rd = 32'h0;
      endcase
      @(negedge clk);
      if (w && cur_nib == 4'hE) m_gpio = d;
      if (w && cur_nib == 4'hF) begin base_cyc = cyc; base_val = d; end
   endtask

   task automatic finish_acc(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.MIO_ready === 1'b1) begin
            seen = 1'b1;
            last_lat = cyc - s_cyc; last_rd = bus.rdata_out;
            chk({nm, " latency"}, 32'(last_lat), 32'(exp_lat));
            if (!cur_w) chk({nm, " rdata"}, last_rd, exp_rd);
            if (cur_w && cur_ram) exp_ram[int'(cur_addr[RAM_AW+1:2])] = cur_wd;
            bus.cpu_req = 1'b0;
         end
         @(negedge clk);
      end
      if (!seen) begin
         n_chk++; n_err++;
         $display("FAIL %s timeout: no MIO_ready within 40 cycles", nm);
      end
   endtask

   task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input string nm);
      start_acc(w, a, d);
      finish_acc(nm);
   endtask

   int t4_s;

   initial begin
      bus.cpu_req = 1'b0; bus.mem_w = 1'b0; bus.addr_in = 32'h0; bus.wdata_in = 32'h0;
      gpio_in = 32'h0; ram_dout = 32'h0;
      for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'h0;
      @(negedge clk);

      // 1: reset held 3 cycles with a pending request
      pulse_reset(3, 1'b1);
      @(negedge clk);

      // 2: RAM store then load
      we_cnt = 0;
      access(1'b1, 32'h0000_0010, 32'h1234_5678, "t2 store");
      chk("t2 store latency literal", 32'(last_lat), 32'd3);
      chk("t2 we pulses", 32'(we_cnt), 32'd1);
      chk("t2 we addr", 32'(we_addr_seen), 32'd4);
      access(1'b0, 32'h0000_0010, 32'h0, "t2 load");
      chk("t2 load latency literal", 32'(last_lat), 32'd3);
      chk("t2 load data literal", last_rd, 32'h1234_5678);
      // top RAM word; low address bits ignored on the load
      access(1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, "top store");
      access(1'b0, 32'h0000_0FFE, 32'h0, "top load");
      chk("top load data literal", last_rd, 32'h0BAD_F00D);
      access(1'b0, 32'h0000_0013, 32'h0, "lowbits load");

      // 3: GPIO store and load
      access(1'b1, 32'hE000_0000, 32'hA5A5_0001, "t3 store");
      chk("t3 latency literal", 32'(last_lat), 32'd1);
      chk("t3 gpio_out literal", gpio_out, 32'hA5A5_0001);
      gpio_in = 32'h0000_000F;
      access(1'b0, 32'hE000_0000, 32'h0, "t3 load");
      chk("t3 load data literal", last_rd, 32'h0000_000F);

      // timer read against the free-running model
      access(1'b0, 32'hF000_0000, 32'h0, "tmr load");

      // 4: timer store near wrap -> single interrupt pulse
      irq_cnt = 0; irq_cyc = -1;
      start_acc(1'b1, 32'hF000_0000, 32'hFFFF_FFFE);
      t4_s = s_cyc;
      finish_acc("t4 store");
      repeat (6) @(negedge clk);
      chk("t4 irq pulses", 32'(irq_cnt), 32'd1);
      chk("t4 irq cycle", 32'(irq_cyc - t4_s), 32'd3);
      access(1'b0, 32'hF000_0004, 32'h0, "t4 tmr load");

      // 5: unmapped region
      access(1'b0, 32'h5000_0000, 32'h0, "t5 load");
      chk("t5 load data literal", last_rd, 32'h0);
      chk("t5 latency literal", 32'(last_lat), 32'd1);
      we_cnt = 0;
      access(1'b1, 32'h5000_0000, 32'h1111_2222, "t5 store");
      chk("t5 no ram_we", 32'(we_cnt), 32'd0);
      chk("t5 gpio kept", gpio_out, 32'hA5A5_0001);
      access(1'b0, 32'hF000_0000, 32'h0, "t5 tmr load");

      // 6: reset during RAM store WAIT aborts it
      we_cnt = 0;
      start_acc(1'b1, 32'h0000_0020, 32'hCAFE_0006);
      pulse_reset(1, 1'b0);
      repeat (4) @(negedge clk);
      chk("t6 no ram_we", 32'(we_cnt), 32'd0);
      chk("t6 ram untouched", mem[8], 32'h0);
      access(1'b0, 32'h0000_0020, 32'h0, "t6 load");
      chk("t6 load data literal", last_rd, 32'h0);
      access(1'b1, 32'h0000_0020, 32'h7777_0006, "t6 store2");
      access(1'b0, 32'h0000_0020, 32'h0, "t6 load2");
      chk("t6 load2 data literal", last_rd, 32'h7777_0006);
      access(1'b0, 32'hF000_0000, 32'h0, "t6 tmr load");

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
